// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between the
//            single-cycle ALU write-back (A) and the long-latency write-back
//            (B, load / mult-div). A has fixed priority. B is forced ahead
//            after STARVE_LIMIT consecutive refused cycles. A pending-write
//            scoreboard tracks in-flight long-latency destinations and raises
//            a read hazard for decode.
// Ports    : clk, rst_n               clock, async active-low reset
//            a_valid/a_rd/a_data      ALU write-back request
//            a_ready                  A accepted this cycle (comb)
//            b_valid/b_rd/b_data      long-latency write-back request
//            b_ready                  B accepted this cycle (comb)
//            iss_valid/iss_rd         long-latency op issued (sets busy)
//            chk_ra/chk_rb            decode source registers
//            hazard                   decode must stall (comb)
//            busy_vec                 scoreboard, bit i = register i pending
//            RegWr/Rw/busW            registered register-file write port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [ADDR_W-1:0]     a_rd,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_W-1:0]     b_rd,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_ready,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic [ADDR_W-1:0]     chk_ra,
  input  logic [ADDR_W-1:0]     chk_rb,
  output logic                  hazard,
  output logic [2**ADDR_W-1:0]  busy_vec,
  output logic                  RegWr,
  output logic [ADDR_W-1:0]     Rw,
  output logic [DATA_W-1:0]     busW
);

  localparam int         NREG  = 2**ADDR_W;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      starve_cnt;
  logic            force_b;
  logic [NREG-1:0] busy_next;
  logic            haz_ra;
  logic            haz_rb;

  // Grant: A wins unless B has been refused long enough.
  assign force_b = b_valid && (starve_cnt >= LIMIT);
  assign a_ready = a_valid && !force_b;
  assign b_ready = b_valid && !a_ready;

  // Starvation counter, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (b_valid && !b_ready) begin
      starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Write port register. Register 0 is accepted but never enables a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWr <= 1'b0;
      Rw    <= '0;
      busW  <= '0;
    end else if (a_ready) begin
      RegWr <= (a_rd != '0);
      Rw    <= a_rd;
      busW  <= a_data;
    end else if (b_ready) begin
      RegWr <= (b_rd != '0);
      Rw    <= b_rd;
      busW  <= b_data;
    end else begin
      RegWr <= 1'b0;
      Rw    <= '0;
      busW  <= '0;
    end
  end

  // Scoreboard update: clear first so a same-index set overrides it.
  always_comb begin
    busy_next = busy_vec;
    if (b_ready) begin
      busy_next[b_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  // The register file reads old contents on the same negedge it writes,
  // so a write still sitting in the output register also counts as a hazard.
  assign haz_ra = (chk_ra != '0) && (busy_vec[chk_ra] || (RegWr && (Rw == chk_ra)));
  assign haz_rb = (chk_rb != '0) && (busy_vec[chk_rb] || (RegWr && (Rw == chk_rb)));
  assign hazard = haz_ra || haz_rb;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter. Expected
//            write-port values are queued when a request is driven and popped
//            after the accepting clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_rd, b_rd, iss_rd, chk_ra, chk_rb;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, hazard;
  logic [31:0] busy_vec;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;

  typedef struct packed {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] bw;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard(hazard), .busy_vec(busy_vec),
    .RegWr(RegWr), .Rw(Rw), .busW(busW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 (or +2). Checks the grant mid-cycle, queues the
  // expected write-port contents, then checks them just after the edge.
  task automatic step(input logic ea, input logic eb,
                      input logic ew, input logic [4:0] erw, input logic [31:0] ebw);
    wr_t got;
    wr_t want;
    #3;
    chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
    chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
    exp_q.push_back('{we: ew, rw: erw, bw: ebw});
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = '{we: RegWr, rw: Rw, bw: busW};
    chk("RegWr", {31'd0, got.we}, {31'd0, want.we});
    chk("Rw",    {27'd0, got.rw}, {27'd0, want.rw});
    chk("busW",  got.bw, want.bw);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_ra = '0; chk_rb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWr", {31'd0, RegWr}, 32'd0);
    chk("rst_Rw", {27'd0, Rw}, 32'd0);
    chk("rst_busW", busW, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    rst_n = 1'b1;

    // Single A write, one-cycle latency, then idle
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    step(1, 0, 1, 5'd5, 32'h0000_1234);
    a_valid = 1'b0;
    step(0, 0, 0, 5'd0, 32'd0);

    // Both requesting: A wins 4 times, then B is forced, then A resumes
    a_valid = 1'b1; a_rd = 5'd1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'h100 + i;
      step(1, 0, 1, 5'd1, 32'h100 + i);
    end
    step(0, 1, 1, 5'd2, 32'hB0);
    a_data = 32'h200;
    step(1, 0, 1, 5'd1, 32'h200);
    b_valid = 1'b0;
    a_valid = 1'b0;
    step(0, 0, 0, 5'd0, 32'd0);

    // Scoreboard set / hazard / clear by B handshake
    iss_valid = 1'b1; iss_rd = 5'd7;
    step(0, 0, 0, 5'd0, 32'd0);
    iss_valid = 1'b0; chk_ra = 5'd7;
    #1;
    chk("busy7_set", busy_vec, 32'h0000_0080);
    chk("haz_busy7", {31'd0, hazard}, 32'd1);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
    step(0, 1, 1, 5'd7, 32'h77);
    b_valid = 1'b0;
    #1;
    chk("busy7_clr", busy_vec, 32'd0);
    chk("haz_inflight7", {31'd0, hazard}, 32'd1);
    step(0, 0, 0, 5'd0, 32'd0);
    #1;
    chk("haz7_gone", {31'd0, hazard}, 32'd0);

    // Register 0: accepted, no write enable, never busy, never a hazard
    chk_ra = 5'd0;
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    step(1, 0, 0, 5'd0, 32'hFFFF_FFFF);
    a_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    step(0, 0, 0, 5'd0, 32'd0);
    iss_valid = 1'b0;
    #1;
    chk("busy_r0", busy_vec, 32'd0);
    chk("haz_r0", {31'd0, hazard}, 32'd0);

    // Same-cycle set and clear on register 9: set wins
    iss_valid = 1'b1; iss_rd = 5'd9;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    step(0, 1, 1, 5'd9, 32'h99);
    iss_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("busy9_setwins", busy_vec, 32'h0000_0200);

    // Asynchronous reset while a write is in flight and busy_vec != 0
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
    step(1, 0, 1, 5'd3, 32'h33);
    a_valid = 1'b0; chk_rb = 5'd9;
    #1;
    chk("haz_pre_rst", {31'd0, hazard}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_RegWr", {31'd0, RegWr}, 32'd0);
    chk("arst_Rw", {27'd0, Rw}, 32'd0);
    chk("arst_busW", busW, 32'd0);
    chk("arst_busy", busy_vec, 32'd0);
    chk("arst_hazard", {31'd0, hazard}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWr/Rw/busW) between two write-back sources.
- Source A is the single-cycle ALU path; source B is the long-latency path (load / mult-div).
- Fixed priority goes to A, with a starvation override for B.
- Holds a 32-entry pending-write scoreboard for long-latency destinations and raises a read hazard for the decode stage.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- STARVE_LIMIT, 4, consecutive refused B cycles before B is forced ahead of A (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  ALU write-back request.
- a_rd  in  ADDR_W  ALU destination register.
- a_data  in  DATA_W  ALU result.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  long-latency write-back request.
- b_rd  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B result.
- b_ready  out  1  B accepted this cycle (combinational).
- iss_valid  in  1  long-latency op issued this cycle.
- iss_rd  in  ADDR_W  destination of the issued op.
- chk_ra  in  ADDR_W  decode source register A.
- chk_rb  in  ADDR_W  decode source register B.
- hazard  out  1  decode must stall (combinational).
- busy_vec  out  2**ADDR_W  scoreboard state, bit i = register i pending.
- RegWr  out  1  register-file write enable (registered).
- Rw  out  ADDR_W  register-file write index (registered).
- busW  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0: RegWr=0, Rw=0, busW=0, busy_vec=0, starve_cnt=0. In-flight requests are dropped; requesters must re-present them after reset.
- Grant (combinational):
  - force_b = b_valid && (starve_cnt >= STARVE_LIMIT).
  - a_ready = a_valid && !force_b.
  - b_ready = b_valid && !a_ready.
  - At most one ready is high per cycle.
  - A handshake is valid && ready sampled at posedge. A requester holds valid, rd and data stable until accepted.
- starve_cnt (4-bit, internal):
  - Increments, saturating at STARVE_LIMIT, when b_valid && !b_ready.
  - Clears to 0 on a B handshake or when b_valid=0.
- Write port register (posedge):
  - RegWr <= (handshake occurred) && (granted rd != 0).
  - Rw <= granted rd; busW <= granted data.
  - With no handshake: RegWr <= 0, Rw <= 0, busW <= 0.
  - Latency: request accepted at posedge N drives RegWr for cycle N..N+1. The register file commits it at the negedge inside that cycle.
  - Writes to register 0 are accepted (ready=1) but never drive RegWr=1.
- Scoreboard busy_vec (posedge):
  - Set: iss_valid && iss_rd != 0 sets busy[iss_rd].
  - Clear: a B handshake clears busy[b_rd].
  - Set and clear on the same index in the same cycle: set wins.
  - busy[0] is permanently 0.
  - A-path writes never modify busy_vec.
  - Re-issue to an already-busy register leaves it busy. Only one clear is required.
- Hazard (combinational), asserted if any of:
  - busy[chk_ra] or busy[chk_rb] is set, for nonzero indices;
  - RegWr=1 and Rw equals a nonzero chk_ra or chk_rb. The register file reads old contents on the same negedge it writes, so a write still in the output register is a hazard.
- Register 0 never causes a hazard.
- No internal buffering: an unaccepted request stays at its source. Back-to-back handshakes on consecutive cycles are fully supported (one write per cycle).

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=0x1234 for 1 cycle -> a_ready=1 same cycle; next cycle RegWr=1, Rw=5, busW=0x00001234; following cycle RegWr=0.
- a_valid and b_valid held high continuously, STARVE_LIMIT=4 -> A accepted 4 cycles; 5th cycle b_ready=1, a_ready=0; starve_cnt returns to 0; A resumes.
- iss_valid, iss_rd=7; then chk_ra=7 -> hazard=1, busy_vec[7]=1. B handshake b_rd=7 -> busy_vec[7]=0 next cycle. hazard stays 1 for the cycle RegWr=1 with Rw=7, then 0.
- a_rd=0, a_data=0xFFFFFFFF accepted -> RegWr stays 0. iss_rd=0 -> busy_vec=0. chk_ra=0 -> hazard=0.
- Same cycle: iss_valid with iss_rd=9 and B handshake with b_rd=9 -> busy_vec[9]=1 afterwards.
- rst_n pulled low mid-stream while RegWr=1 and busy_vec!=0 -> immediately RegWr=0, Rw=0, busW=0, busy_vec=0, hazard=0, without waiting for a clock edge.
